// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the multi-position shift engine:
//   - state_t       : sequencer states (IDLE / SHIFT / DONE)
//   - DIR_LEFT/RIGHT: encoding of the dir input
//   - calc_amt_eff  : maps a requested amount to the number of single-position
//                     steps actually performed
// ---------------------------------------------------------------------------
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Plain shifts saturate at n, because anything beyond n positions pushes
  // the whole operand out and further steps change nothing but carry.
  // Rotations wrap instead; the amount input can encode at most 2n-1, so a
  // single subtraction is enough to reduce it modulo n.
  function automatic int calc_amt_eff(input int amount, input int n, input logic rot);
    int eff;
    if (rot) begin
      eff = (amount >= n) ? amount - n : amount;
    end else begin
      eff = (amount > n) ? n : amount;
    end
    return eff;
  endfunction

endpackage

// File: rtl/shift_step.sv
// ---------------------------------------------------------------------------
// shift_step
// Combinational single-position shift/rotate step.
//   value   [N-1:0] in  : operand before the step
//   dir             in  : DIR_LEFT or DIR_RIGHT
//   rot             in  : 1 = rotate (leaving bit re-enters at the other end)
//   shifted [N-1:0] out : operand after the step
//   out_bit         out : bit that left the operand during this step
// Left shifts fill bit 0 with zero; right shifts are arithmetic (the MSB
// replicates itself).
// ---------------------------------------------------------------------------
module shift_step
  import shift_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] value,
  input  logic         dir,
  input  logic         rot,
  output logic [N-1:0] shifted,
  output logic         out_bit
);

  always_comb begin
    shifted = value;
    out_bit = 1'b0;
    case (dir)
      DIR_LEFT: begin
        out_bit = value[N-1];
        shifted = {value[N-2:0], (rot ? value[N-1] : 1'b0)};
      end
      DIR_RIGHT: begin
        out_bit = value[0];
        // Rotation feeds bit 0 back in at the top; otherwise sign-extend.
        shifted = {(rot ? value[0] : value[N-1]), value[N-1:1]};
      end
      default: begin
        shifted = value;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
// Multi-position shift engine for the lab ALU datapath. An operand and shift
// amount are captured on start, then shifted one position per clock through
// a single shift_step instance. A one-cycle done pulse marks the result.
//
// Ports:
//   clk                 in  : system clock, rising edge
//   rst_n               in  : asynchronous active-low reset
//   start               in  : request, only honoured in IDLE
//   dir                 in  : 0 = left, 1 = right (arithmetic)
//   amount   [AW-1:0]   in  : requested shift positions
//   a_in     [N-1:0]    in  : operand
//   rot                 in  : 1 = rotate instead of shift (only when
//                             SHIFT_SEQUENCER_ROTATE_EN is defined)
//   result   [N-1:0]    out : shifted operand, valid with done, held until
//                             the next accepted start
//   carry_out           out : last bit shifted out (0 for a zero amount)
//   busy                out : high while shifting
//   done                out : one-cycle completion pulse
//
// Build option:
//   SHIFT_SEQUENCER_ROTATE_EN - adds the rot port and rotation support;
//   without it only shifts are available and amounts saturate at N.
// ---------------------------------------------------------------------------
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int N  = 8,
  parameter int AW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          dir,
  input  logic [AW-1:0] amount,
  input  logic [N-1:0]  a_in,
`ifdef SHIFT_SEQUENCER_ROTATE_EN
  input  logic          rot,
`endif
  output logic [N-1:0]  result,
  output logic          carry_out,
  output logic          busy,
  output logic          done
);

  state_t        state;
  logic [N-1:0]  work;
  logic          dir_q;
  logic          rot_q;
  logic [AW-1:0] count;
  logic          rot_sel;
  logic [AW-1:0] amt_eff;
  logic [N-1:0]  step_value;
  logic          step_out_bit;

  // Rotation request seen at the input; tied off when the feature is absent
  // so the rest of the datapath is identical in both builds.
`ifdef SHIFT_SEQUENCER_ROTATE_EN
  assign rot_sel = rot;
`else
  assign rot_sel = 1'b0;
`endif

  // Number of single-position steps the requested amount turns into.
  always_comb begin
    amt_eff = AW'(calc_amt_eff(int'(amount), N, rot_sel));
  end

  shift_step #(
    .N(N)
  ) u_step (
    .value  (work),
    .dir    (dir_q),
    .rot    (rot_q),
    .shifted(step_value),
    .out_bit(step_out_bit)
  );

  // Sequencer: capture on start in IDLE, step once per cycle in SHIFT,
  // pulse done for one cycle, then return to IDLE. The working register is
  // also the visible result, so it simply holds after DONE until the next
  // accepted start. A zero amount skips SHIFT and goes straight to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      work      <= '0;
      dir_q     <= DIR_LEFT;
      rot_q     <= 1'b0;
      count     <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work      <= a_in;
            dir_q     <= dir;
            rot_q     <= rot_sel;
            count     <= amt_eff;
            carry_out <= 1'b0;
            state     <= (amt_eff != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          work      <= step_value;
          carry_out <= step_out_bit;
          count     <= count - AW'(1);
          if (count == AW'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign result = work;
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-position shift engine for the lab ALU datapath. It accepts an operand and a shift amount, then performs the shift one position per clock through a single-position shift step. It returns the result, and the last bit shifted out, with a done pulse. It sits between the operand/control registers and the ALU result mux.

Parameters:
N, 8, operand width in bits (N >= 2)
AW, $clog2(N)+1, width of the amount input (must be able to encode N)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only in IDLE
dir  input  1  0 = left shift, 1 = right shift; sampled with start
amount  input  AW  requested shift positions; sampled with start
a_in  input  N  operand; sampled with start
result  output  N  shifted operand; valid while done=1, held until next accepted start
carry_out  output  1  last bit shifted out; 0 if effective amount is 0
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse, result valid

Behaviour:
- Reset (async assert, sync release): state=IDLE; result=0, carry_out=0, busy=0, done=0; internal count=0.
- Effective amount: amt_eff = min(amount, N). Values above N saturate to N.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1 at an edge:
  - load a_in into the working register; latch dir; count=amt_eff; carry_out=0.
  - next state is SHIFT if amt_eff>0, otherwise DONE.
- IDLE, start=0: stay in IDLE; outputs hold.
- SHIFT, each edge:
  - shift the register one position; carry_out = the bit leaving the register.
  - count decrements; when count==1 before the edge, next state is DONE.
- Fill rules:
  - left shift: bit 0 fills with 0; MSB leaves to carry_out.
  - right shift: arithmetic; MSB replicates itself; bit 0 leaves to carry_out.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Latency: done is high in the cycle after edge (k + amt_eff), where k is the accepting edge. Minimum latency is 1 cycle (amount=0).
- start in SHIFT or DONE is ignored; it is not queued. A fresh start is needed in IDLE.
- dir, amount and a_in changes after acceptance have no effect.
- result/carry_out stay stable from DONE until the next accepted start.
- rst_n low mid-operation aborts immediately to reset values; no done is issued.
- busy = (state==SHIFT). done and busy are never high together.

Optional Feature:
- Macro: SHIFT_SEQUENCER_ROTATE_EN.
- Defined:
  - adds input port rot (1 bit), sampled with start.
  - rot=1 selects rotation: the bit leaving one end re-enters the other end and is also copied to carry_out.
  - amt_eff = amount mod N, computed as amount−N when amount>=N; values up to 2N−1 are covered by AW.
  - rot=0 behaves exactly as the undefined case.
- Undefined: no rot port; shifts only, with the saturation rule above.

Decomposition:
- Shared package shift_pkg:
  - state enum type (IDLE/SHIFT/DONE).
  - direction constants DIR_LEFT=1'b0, DIR_RIGHT=1'b1.
  - function computing amt_eff.
- Natural sub-module: shift_step, a combinational one-position step.
  - Inputs: value, dir, rot.
  - Outputs: shifted value, out bit.
  - Instantiated once inside shift_sequencer; the FSM and counter stay in the top module.

Test Plan (N=8):
- a_in=0x81, dir=0, amount=1, start pulse -> done one cycle after the SHIFT edge; result=0x02, carry_out=1; busy high exactly 1 cycle.
- a_in=0x80, dir=1, amount=3 -> busy 3 cycles; result=0xF0, carry_out=0; done single-cycle.
- a_in=0x5A, amount=0 -> done in the cycle after the accepting edge; busy never high; result=0x5A, carry_out=0.
- a_in=0xFF, dir=0, amount=12 -> saturates to 8 shifts; result=0x00, carry_out=1. Then a_in=0x7F, dir=1, amount=9 -> result=0x00, carry_out=0.
- Start with amount=5; assert start again on SHIFT cycle 2, changing a_in -> ignored; original result delivered. Then start amount=6 and drop rst_n on SHIFT cycle 3 -> all outputs 0 immediately; no done; next start works normally.
- With SHIFT_SEQUENCER_ROTATE_EN defined:
  - rot=1, dir=0, a_in=0x81, amount=1 -> result=0x03, carry_out=1.
  - rot=1, dir=1, a_in=0x01, amount=9 -> result=0x80, carry_out=1.
